// File: rtl/muldiv.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// One shift-add or restoring-divide step per cycle, sign fix-up in FIX, atomic HI/LO write.
module muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             valid_in,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]        cnt_load = CW'(WIDTH);
    localparam logic [CW-1:0]        cnt_one  = CW'(1);
    localparam logic [WIDTH-1:0]     one_w    = WIDTH'(1);
    localparam logic [2*WIDTH-1:0]   one_2w   = (2*WIDTH)'(1);

    typedef enum logic [1:0] {IDLE, BUSY, FIX, DONE} state_t;

    state_t               state_reg;
    logic [CW-1:0]        cnt_reg;
    logic                 ready_reg;
    logic                 done_reg;
    logic [WIDTH-1:0]     hi_reg;
    logic [WIDTH-1:0]     lo_reg;
    logic                 is_div_reg;
    logic                 neg_q_reg;
    logic                 neg_r_reg;
    logic                 div_zero_reg;
    logic [WIDTH-1:0]     mcand_reg;
    logic [2*WIDTH-1:0]   work_reg;

    // Operand decode and magnitudes on the request side
    logic             op_signed;
    logic             sign_a;
    logic             sign_b;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;

    always_comb begin
        op_signed = ~op[0];
        sign_a    = op_signed & a[WIDTH-1];
        sign_b    = op_signed & b[WIDTH-1];
        mag_a     = sign_a ? (~a + one_w) : a;
        mag_b     = sign_b ? (~b + one_w) : b;
    end

    // Multiply step: conditionally add the multiplicand to the upper half, then shift right
    logic [WIDTH-1:0]   mul_addend;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_addend
        assign mul_addend[gi] = mcand_reg[gi] & work_reg[0];
    end

    always_comb begin
        mul_sum  = {1'b0, work_reg[2*WIDTH-1:WIDTH]} + {1'b0, mul_addend};
        mul_next = {mul_sum, work_reg[WIDTH-1:1]};
    end

    // Restoring divide step: work holds {remainder, remaining dividend / growing quotient}
    logic [WIDTH:0]     rem_shift;
    logic [WIDTH:0]     div_diff;
    logic               div_ge;
    logic [2*WIDTH-1:0] div_next;

    always_comb begin
        rem_shift = work_reg[2*WIDTH-1:WIDTH-1];
        div_diff  = rem_shift - {1'b0, mcand_reg};
        div_ge    = rem_shift >= {1'b0, mcand_reg};
        div_next  = {(div_ge ? div_diff[WIDTH-1:0] : rem_shift[WIDTH-1:0]),
                     work_reg[WIDTH-2:0], div_ge};
    end

    // Sign correction applied on the FIX edge
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix;
    logic [WIDTH-1:0]   rem_fix;
    logic [WIDTH-1:0]   fix_hi;
    logic [WIDTH-1:0]   fix_lo;

    always_comb begin
        prod_fix = neg_q_reg ? (~work_reg + one_2w) : work_reg;
        quot_fix = neg_q_reg ? (~work_reg[WIDTH-1:0] + one_w) : work_reg[WIDTH-1:0];
        rem_fix  = neg_r_reg ? (~work_reg[2*WIDTH-1:WIDTH] + one_w) : work_reg[2*WIDTH-1:WIDTH];
        if (is_div_reg) begin
            // Divide by zero leaves all-ones quotient and |a| as remainder; skip quotient negation
            fix_lo = div_zero_reg ? {WIDTH{1'b1}} : quot_fix;
            fix_hi = rem_fix;
        end else begin
            fix_lo = prod_fix[WIDTH-1:0];
            fix_hi = prod_fix[2*WIDTH-1:WIDTH];
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            ready_reg    <= 1'b1;
            done_reg     <= 1'b0;
            hi_reg       <= '0;
            lo_reg       <= '0;
            is_div_reg   <= 1'b0;
            neg_q_reg    <= 1'b0;
            neg_r_reg    <= 1'b0;
            div_zero_reg <= 1'b0;
            mcand_reg    <= '0;
            work_reg     <= '0;
        end else if (flush) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            ready_reg <= 1'b1;
            done_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE, DONE: begin
                    done_reg <= 1'b0;
                    if (valid_in) begin
                        case (op)
                            3'b000, 3'b001, 3'b010, 3'b011: begin
                                state_reg    <= BUSY;
                                ready_reg    <= 1'b0;
                                cnt_reg      <= cnt_load;
                                is_div_reg   <= op[1];
                                neg_q_reg    <= sign_a ^ sign_b;
                                neg_r_reg    <= sign_a;
                                div_zero_reg <= (b == '0);
                                mcand_reg    <= op[1] ? mag_b : mag_a;
                                work_reg     <= {{WIDTH{1'b0}}, (op[1] ? mag_a : mag_b)};
                            end
                            3'b100: begin
                                hi_reg    <= a;
                                state_reg <= DONE;
                                done_reg  <= 1'b1;
                            end
                            3'b101: begin
                                lo_reg    <= a;
                                state_reg <= DONE;
                                done_reg  <= 1'b1;
                            end
                            default: begin
                                state_reg <= DONE;
                                done_reg  <= 1'b1;
                            end
                        endcase
                    end else begin
                        state_reg <= IDLE;
                    end
                end
                BUSY: begin
                    work_reg <= is_div_reg ? div_next : mul_next;
                    cnt_reg  <= cnt_reg - cnt_one;
                    if (cnt_reg == cnt_one) begin
                        state_reg <= FIX;
                    end
                end
                FIX: begin
                    hi_reg    <= fix_hi;
                    lo_reg    <= fix_lo;
                    state_reg <= DONE;
                    ready_reg <= 1'b1;
                    done_reg  <= 1'b1;
                end
                default: begin
                    state_reg <= IDLE;
                    ready_reg <= 1'b1;
                    done_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign ready = ready_reg;
    assign done  = done_reg;
    assign hi    = hi_reg;
    assign lo    = lo_reg;

endmodule

// File: tb/tb_muldiv.sv
// Directed testbench for muldiv: latency, signed/unsigned results, divide corner cases,
// flush, reset mid-operation and back-to-back acceptance.
module tb_muldiv;

    logic        clk;
    logic        resetn;
    logic        valid_in;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        ready;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;
    localparam logic [2:0] OP_NOP   = 3'b110;

    muldiv #(.WIDTH(32)) dut (
        .clk      (clk),
        .resetn   (resetn),
        .valid_in (valid_in),
        .op       (op),
        .a        (a),
        .b        (b),
        .flush    (flush),
        .ready    (ready),
        .done     (done),
        .hi       (hi),
        .lo       (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one op, wait for its accept edge, then count negedge samples until done.
    // lat = index of the done sample (0 = cycle right after the accept edge), -1 if none.
    task automatic run_op(input logic [2:0] o, input logic [31:0] aa, input logic [31:0] bb,
                          output int lat, output int busy);
        @(negedge clk);
        valid_in = 1'b1;
        op = o;
        a = aa;
        b = bb;
        for (int t = 0; t < 100 && !ready; t++) @(negedge clk);
        @(negedge clk);
        valid_in = 1'b0;
        lat = -1;
        busy = 0;
        for (int j = 0; j < 100; j++) begin
            if (!ready) busy++;
            if (done) begin
                lat = j;
                break;
            end
            @(negedge clk);
        end
        $display("op=%b a=%h b=%h -> lat=%0d busy=%0d hi=%h lo=%h", o, aa, bb, lat, busy, hi, lo);
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        n_cmp++; if (hi !== 32'h0)   begin n_bad++; $display("FAIL reset_hi got=%h exp=%h", hi, 32'h0); end
        n_cmp++; if (lo !== 32'h0)   begin n_bad++; $display("FAIL reset_lo got=%h exp=%h", lo, 32'h0); end
        n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready got=%b exp=1", ready); end
        n_cmp++; if (done !== 1'b0)  begin n_bad++; $display("FAIL reset_done got=%b exp=0", done); end
        $display("reset: hi=%h lo=%h ready=%b done=%b", hi, lo, ready, done);
    endtask

    task automatic test_mult();
        int lat, busy;
        run_op(OP_MULT, 32'hFFFFFFFD, 32'd7, lat, busy);
        n_cmp++; if (lat !== 33)  begin n_bad++; $display("FAIL mult_latency got=%0d exp=33", lat); end
        n_cmp++; if (busy !== 33) begin n_bad++; $display("FAIL mult_ready_low got=%0d exp=33", busy); end
        n_cmp++; if (hi !== 32'hFFFFFFFF) begin n_bad++; $display("FAIL mult_hi got=%h exp=FFFFFFFF", hi); end
        n_cmp++; if (lo !== 32'hFFFFFFEB) begin n_bad++; $display("FAIL mult_lo got=%h exp=FFFFFFEB", lo); end
        n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL mult_done_ready got=%b exp=1", ready); end
        run_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, busy);
        n_cmp++; if (hi !== 32'hFFFFFFFE) begin n_bad++; $display("FAIL multu_hi got=%h exp=FFFFFFFE", hi); end
        n_cmp++; if (lo !== 32'h00000001) begin n_bad++; $display("FAIL multu_lo got=%h exp=00000001", lo); end
        run_op(OP_MULT, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, busy);
        n_cmp++; if (hi !== 32'h0) begin n_bad++; $display("FAIL mult_negneg_hi got=%h exp=00000000", hi); end
        n_cmp++; if (lo !== 32'h1) begin n_bad++; $display("FAIL mult_negneg_lo got=%h exp=00000001", lo); end
    endtask

    task automatic test_div();
        int lat, busy;
        run_op(OP_DIV, 32'hFFFFFFF9, 32'd2, lat, busy);
        n_cmp++; if (lat !== 33) begin n_bad++; $display("FAIL div_latency got=%0d exp=33", lat); end
        n_cmp++; if (lo !== 32'hFFFFFFFD) begin n_bad++; $display("FAIL div_neg_lo got=%h exp=FFFFFFFD", lo); end
        n_cmp++; if (hi !== 32'hFFFFFFFF) begin n_bad++; $display("FAIL div_neg_hi got=%h exp=FFFFFFFF", hi); end
        run_op(OP_DIV, 32'd7, 32'hFFFFFFFE, lat, busy);
        n_cmp++; if (lo !== 32'hFFFFFFFD) begin n_bad++; $display("FAIL div_negb_lo got=%h exp=FFFFFFFD", lo); end
        n_cmp++; if (hi !== 32'h1) begin n_bad++; $display("FAIL div_negb_hi got=%h exp=00000001", hi); end
        run_op(OP_DIVU, 32'd7, 32'd2, lat, busy);
        n_cmp++; if (lo !== 32'd3) begin n_bad++; $display("FAIL divu_lo got=%h exp=00000003", lo); end
        n_cmp++; if (hi !== 32'd1) begin n_bad++; $display("FAIL divu_hi got=%h exp=00000001", hi); end
        run_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF, lat, busy);
        n_cmp++; if (lo !== 32'h80000000) begin n_bad++; $display("FAIL div_ovf_lo got=%h exp=80000000", lo); end
        n_cmp++; if (hi !== 32'h0) begin n_bad++; $display("FAIL div_ovf_hi got=%h exp=00000000", hi); end
        run_op(OP_DIVU, 32'hFFFFFFFF, 32'h10000, lat, busy);
        n_cmp++; if (lo !== 32'h0000FFFF) begin n_bad++; $display("FAIL divu_big_lo got=%h exp=0000FFFF", lo); end
        n_cmp++; if (hi !== 32'h0000FFFF) begin n_bad++; $display("FAIL divu_big_hi got=%h exp=0000FFFF", hi); end
    endtask

    task automatic test_div_zero();
        int lat, busy;
        run_op(OP_DIVU, 32'h1234, 32'h0, lat, busy);
        n_cmp++; if (lat !== 33) begin n_bad++; $display("FAIL divz_latency got=%0d exp=33", lat); end
        n_cmp++; if (lo !== 32'hFFFFFFFF) begin n_bad++; $display("FAIL divuz_lo got=%h exp=FFFFFFFF", lo); end
        n_cmp++; if (hi !== 32'h1234) begin n_bad++; $display("FAIL divuz_hi got=%h exp=00001234", hi); end
        run_op(OP_DIV, 32'hFFFFFFF8, 32'h0, lat, busy);
        n_cmp++; if (lo !== 32'hFFFFFFFF) begin n_bad++; $display("FAIL divz_lo got=%h exp=FFFFFFFF", lo); end
        n_cmp++; if (hi !== 32'hFFFFFFF8) begin n_bad++; $display("FAIL divz_hi got=%h exp=FFFFFFF8", hi); end
    endtask

    task automatic test_mt_nop();
        int lat, busy;
        logic [31:0] hi_before, lo_before;
        run_op(OP_MTHI, 32'hCAFE0001, 32'h0, lat, busy);
        n_cmp++; if (lat !== 0) begin n_bad++; $display("FAIL mthi_latency got=%0d exp=0", lat); end
        n_cmp++; if (busy !== 0) begin n_bad++; $display("FAIL mthi_ready got=%0d exp=0", busy); end
        n_cmp++; if (hi !== 32'hCAFE0001) begin n_bad++; $display("FAIL mthi_hi got=%h exp=CAFE0001", hi); end
        hi_before = hi;
        lo_before = lo;
        run_op(OP_NOP, 32'h55555555, 32'h0, lat, busy);
        n_cmp++; if (lat !== 0) begin n_bad++; $display("FAIL nop_latency got=%0d exp=0", lat); end
        n_cmp++; if (hi !== hi_before || lo !== lo_before)
            begin n_bad++; $display("FAIL nop_hilo got=%h/%h exp=%h/%h", hi, lo, hi_before, lo_before); end
    endtask

    task automatic test_flush();
        int lat, busy, seen;
        logic [31:0] lo_before;
        run_op(OP_MTHI, 32'd5, 32'h0, lat, busy);
        n_cmp++; if (lat !== 0) begin n_bad++; $display("FAIL flush_mthi_latency got=%0d exp=0", lat); end
        n_cmp++; if (hi !== 32'd5) begin n_bad++; $display("FAIL flush_mthi_hi got=%h exp=00000005", hi); end
        lo_before = lo;
        @(negedge clk);
        valid_in = 1'b1; op = OP_MULT; a = 32'd3; b = 32'd4;
        @(negedge clk);
        valid_in = 1'b0;
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL flush_ready got=%b exp=1", ready); end
        seen = 0;
        for (int j = 0; j < 40; j++) begin
            if (done) seen++;
            @(negedge clk);
        end
        n_cmp++; if (seen !== 0) begin n_bad++; $display("FAIL flush_no_done got=%0d exp=0", seen); end
        n_cmp++; if (hi !== 32'd5) begin n_bad++; $display("FAIL flush_hi got=%h exp=00000005", hi); end
        n_cmp++; if (lo !== lo_before) begin n_bad++; $display("FAIL flush_lo got=%h exp=%h", lo, lo_before); end
        $display("flush: hi=%h lo=%h ready=%b dones=%0d", hi, lo, ready, seen);
    endtask

    task automatic test_back_to_back();
        int lat;
        @(negedge clk);
        valid_in = 1'b1; op = OP_MULTU; a = 32'd2; b = 32'd3;
        @(negedge clk);
        valid_in = 1'b0;
        lat = -1;
        for (int j = 0; j < 100; j++) begin
            if (done) begin lat = j; break; end
            @(negedge clk);
        end
        n_cmp++; if (lat !== 33) begin n_bad++; $display("FAIL b2b_latency got=%0d exp=33", lat); end
        n_cmp++; if (lo !== 32'd6) begin n_bad++; $display("FAIL b2b_mul_lo got=%h exp=00000006", lo); end
        n_cmp++; if (hi !== 32'd0) begin n_bad++; $display("FAIL b2b_mul_hi got=%h exp=00000000", hi); end
        valid_in = 1'b1; op = OP_MTLO; a = 32'd9;
        @(negedge clk);
        valid_in = 1'b0;
        n_cmp++; if (lo !== 32'd9) begin n_bad++; $display("FAIL b2b_mtlo_lo got=%h exp=00000009", lo); end
        n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL b2b_mtlo_done got=%b exp=1", done); end
        n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL b2b_mtlo_ready got=%b exp=1", ready); end
        $display("back_to_back: hi=%h lo=%h done=%b", hi, lo, done);
    endtask

    task automatic test_blocking();
        int lat, early;
        @(negedge clk);
        valid_in = 1'b1; op = OP_MULTU; a = 32'd1; b = 32'd1;
        @(negedge clk);
        op = OP_MTLO; a = 32'h77;
        lat = -1;
        early = 0;
        for (int j = 0; j < 100; j++) begin
            if (done) begin lat = j; break; end
            if (lo === 32'h77) early++;
            @(negedge clk);
        end
        n_cmp++; if (early !== 0) begin n_bad++; $display("FAIL block_early_accept got=%0d exp=0", early); end
        n_cmp++; if (lo !== 32'd1) begin n_bad++; $display("FAIL block_mul_lo got=%h exp=00000001", lo); end
        @(negedge clk);
        valid_in = 1'b0;
        n_cmp++; if (lo !== 32'h77) begin n_bad++; $display("FAIL block_mtlo_lo got=%h exp=00000077", lo); end
        n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL block_mtlo_done got=%b exp=1", done); end
        $display("blocking: lat=%0d lo=%h done=%b", lat, lo, done);
    endtask

    task automatic test_reset_busy();
        int lat, busy, seen;
        run_op(OP_MTHI, 32'hAB, 32'h0, lat, busy);
        @(negedge clk);
        valid_in = 1'b1; op = OP_MULT; a = 32'd3; b = 32'd4;
        @(negedge clk);
        valid_in = 1'b0;
        repeat (5) @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        n_cmp++; if (hi !== 32'h0) begin n_bad++; $display("FAIL rstbusy_hi got=%h exp=00000000", hi); end
        n_cmp++; if (lo !== 32'h0) begin n_bad++; $display("FAIL rstbusy_lo got=%h exp=00000000", lo); end
        n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL rstbusy_ready got=%b exp=1", ready); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL rstbusy_done got=%b exp=0", done); end
        seen = 0;
        for (int j = 0; j < 40; j++) begin
            if (done) seen++;
            @(negedge clk);
        end
        n_cmp++; if (seen !== 0) begin n_bad++; $display("FAIL rstbusy_no_done got=%0d exp=0", seen); end
        $display("reset_busy: hi=%h lo=%h ready=%b dones=%0d", hi, lo, ready, seen);
    endtask

    initial begin
        resetn = 1'b0;
        valid_in = 1'b0;
        op = 3'b000;
        a = '0;
        b = '0;
        flush = 1'b0;
        test_reset();
        test_mult();
        test_div();
        test_div_zero();
        test_mt_nop();
        test_flush();
        test_back_to_back();
        test_blocking();
        test_reset_busy();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/muldiv.md
# muldiv

Parametrised iterative multiply/divide unit with architectural HI/LO registers. It sits in the execute stage beside the single-cycle ALU and handles MULT, MULTU, DIV, DIVU, MTHI and MTLO. Operands are accepted through a valid/ready handshake. Multiply and divide run one bit per cycle; sign correction is applied at the end, and HI/LO update atomically on completion. A flush input kills an in-flight operation without disturbing HI/LO.

## Interface
- WIDTH, 32: operand width and width of each of HI and LO.
- clk  in  1  clock; all state updates on the rising edge.
- resetn  in  1  synchronous, active-low reset.
- valid_in  in  1  operation request; accepted on an edge where valid_in && ready && !flush.
- op  in  3  operation code:
  - 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO.
  - 110 and 111 are no-ops.
- a  in  WIDTH  rs operand: dividend, multiplicand, or MT source.
- b  in  WIDTH  rt operand: divisor or multiplier; ignored for MT ops.
- flush  in  1  abort any in-flight op; has priority over valid_in.
- ready  out  1  unit can accept an op this cycle.
- done  out  1  one-cycle pulse; the HI/LO result of the accepted op is visible this cycle.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

## Operation
- Reset (resetn=0 on an edge): state IDLE, hi=0, lo=0, ready=1, done=0, counter=0. Reset mid-operation discards the op with no done.
- States:
  - IDLE: ready=1.
  - BUSY: ready=0.
  - FIX: ready=0, one cycle.
  - DONE: ready=1, done=1, one cycle.
- IDLE/DONE accepting MULT..DIVU → BUSY:
  - Latch the sign flags and the operand magnitudes.
  - Signed ops take two's-complement absolute values; unsigned ops take raw values.
  - Load counter=WIDTH.
- IDLE/DONE accepting MTHI/MTLO → DONE: hi (or lo) ← a on the accept edge.
- IDLE/DONE accepting 110/111 → DONE; hi/lo unchanged.
- IDLE/DONE with no accept → IDLE.
- BUSY: one iteration per cycle and counter decrements. When counter reaches 0 after the final iteration → FIX.
  - Multiply: shift-add over a 2·WIDTH unsigned product of the magnitudes.
  - Divide: restoring division producing a WIDTH-bit quotient and remainder of the magnitudes.
- FIX: apply sign correction, then write hi/lo → DONE.
  - MULT: negate the 2·WIDTH product when sign(a)≠sign(b). hi=upper half, lo=lower half.
  - DIV: negate the quotient when sign(a)≠sign(b); the remainder takes the sign of a. lo=quotient, hi=remainder.
  - MULTU/DIVU: no correction.
- Division by zero (b=0, DIV or DIVU): full latency, lo={WIDTH{1}}, hi=a unmodified.
- Signed overflow case (DIV of the most negative value by −1): lo=most negative value (wraps), hi=0. No trap.
- Arithmetic is modulo 2^WIDTH per register; no overflow output.
- flush=1 on an edge:
  - Next state IDLE; counter cleared; hi/lo unchanged.
  - No done for the killed op. A done already asserted in the current cycle stands.

## Timing
- MULT/MULTU/DIV/DIVU accepted on edge k:
  - ready=0 from edge k to edge k+WIDTH+1.
  - hi/lo written on edge k+WIDTH+1.
  - done=1 and ready=1 in the cycle after edge k+WIDTH+1.
  - Total latency WIDTH+1 cycles to done.
- MTHI/MTLO/no-op accepted on edge k: hi/lo written on edge k (MT only); done=1 in the following cycle. ready stays 1.
- The DONE cycle may accept a new op: back-to-back throughput is WIDTH+2 cycles per mul/div, and 1 op per cycle for MT ops.
- Requests while ready=0 are not accepted; the requester holds valid_in/op/a/b.
- hi/lo are registered and never change outside the write edges above.

## Test plan
- MULT a=0xFFFFFFFD (−3), b=7 → done exactly 33 cycles after the accept edge; hi=0xFFFFFFFF, lo=0xFFFFFFEB. ready low for 33 cycles.
- MULTU a=b=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001.
- Divide cases:
  - DIV a=0xFFFFFFF9 (−7), b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - DIVU a=7, b=2 → lo=3, hi=1.
  - DIV a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0.
- DIVU a=0x1234, b=0 → after 33 cycles lo=0xFFFFFFFF, hi=0x1234.
- Flush mid-operation:
  - MTHI a=5 → done next cycle, hi=5.
  - Then MULT 3×4, with flush on the 10th BUSY cycle → no done ever, hi=5, lo unchanged, ready=1 the cycle after the flush edge.
- Back-to-back and blocking:
  - MULTU 2×3 with a new MTLO a=9 presented in its DONE cycle → lo=6 visible in the DONE cycle; lo=9 on the next edge, with done in the following cycle.
  - MTLO presented during BUSY is not accepted until ready=1.
  - resetn=0 mid-BUSY → hi=lo=0, ready=1, done=0.
